// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states and
// a helper that turns a size code into a byte count.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Returns 0 for the illegal size code so callers can flag it separately.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin two-port front end for the single-port data_memory: one request,
// one access, one registered response. Define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned accesses.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_write,
    input  logic [1:0]        req0_size,
    input  logic              req0_unsigned,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_write,
    input  logic [1:0]        req1_size,
    input  logic              req1_unsigned,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic              mem_unsigned_load,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

    state_t            state_reg;
    logic              last_grant_reg;
    logic              port_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              write_reg;
    logic [1:0]        size_reg;
    logic              unsigned_reg;
    logic [1:0]        rsp_valid_reg;
    logic [1:0]        err_reg;
    logic [DATA_W-1:0] rdata_reg [2];

    logic              grant;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_write;
    logic [1:0]        sel_size;
    logic              sel_unsigned;
    logic [ADDR_W:0]   end_addr;
    logic              range_err;
    logic              size_err;
    logic              align_err;
    logic              req_bad;
    logic              in_access;

    // Contention goes to the port that did not win last time.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_reg;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept     = (state_reg == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = reset && (state_reg == ST_IDLE) && req0_valid && !grant;
    assign req1_ready = reset && (state_reg == ST_IDLE) && req1_valid && grant;

    assign sel_addr     = grant ? req1_addr     : req0_addr;
    assign sel_wdata    = grant ? req1_wdata    : req0_wdata;
    assign sel_write    = grant ? req1_write    : req0_write;
    assign sel_size     = grant ? req1_size     : req0_size;
    assign sel_unsigned = grant ? req1_unsigned : req0_unsigned;

    // One extra bit keeps addresses near the top of the space from wrapping.
    assign end_addr  = {1'b0, sel_addr} + {{(ADDR_W - 2){1'b0}}, size_bytes(sel_size)};
    assign range_err = end_addr > MEM_LIMIT;
    assign size_err  = (sel_size == 2'b11);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign align_err = ((sel_size == SZ_HALF) && sel_addr[0]) ||
                       ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));
`else
    assign align_err = 1'b0;
`endif

    assign req_bad = range_err || size_err || align_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            port_reg       <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            write_reg      <= 1'b0;
            size_reg       <= SZ_BYTE;
            unsigned_reg   <= 1'b0;
            rsp_valid_reg  <= '0;
            err_reg        <= '0;
            rdata_reg[0]   <= '0;
            rdata_reg[1]   <= '0;
        end else begin
            rsp_valid_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        port_reg       <= grant;
                        last_grant_reg <= grant;
                        addr_reg       <= sel_addr;
                        wdata_reg      <= sel_wdata;
                        write_reg      <= sel_write;
                        size_reg       <= sel_size;
                        unsigned_reg   <= sel_unsigned;
                        if (req_bad) begin
                            state_reg             <= ST_RESP;
                            rsp_valid_reg[grant]  <= 1'b1;
                            err_reg[grant]        <= 1'b1;
                            rdata_reg[grant]      <= '0;
                        end else begin
                            state_reg <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    state_reg                <= ST_RESP;
                    rsp_valid_reg[port_reg]  <= 1'b1;
                    err_reg[port_reg]        <= 1'b0;
                    rdata_reg[port_reg]      <= write_reg ? '0 : mem_read_data;
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp0_err   = err_reg[0];
    assign rsp1_err   = err_reg[1];
    assign rsp0_rdata = rdata_reg[0];
    assign rsp1_rdata = rdata_reg[1];

    // Decoded from the async-reset state so mem_write falls the moment reset asserts.
    assign in_access         = (state_reg == ST_ACCESS);
    assign mem_read          = in_access && !write_reg;
    assign mem_write         = in_access && write_reg;
    assign mem_address       = in_access ? addr_reg  : '0;
    assign mem_write_data    = in_access ? wdata_reg : '0;
    assign mem_size          = in_access ? size_reg  : SZ_BYTE;
    assign mem_unsigned_load = in_access && unsigned_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed behavioural data_memory.
// Alignment expectations follow DMEM_ARB_ALIGN_CHECK_EN.
module tb_dmem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 1024;

    logic              clk;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic              req0_write, req1_write;
    logic [1:0]        req0_size, req1_size;
    logic              req0_unsigned, req1_unsigned;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              rsp0_err, rsp1_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read, mem_write;
    logic [1:0]        mem_size;
    logic              mem_unsigned_load;
    logic [DATA_W-1:0] mem_read_data;

    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_write(req0_write), .req0_size(req0_size),
        .req0_unsigned(req0_unsigned),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_write(req1_write), .req1_size(req1_size),
        .req1_unsigned(req1_unsigned),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned_load(mem_unsigned_load), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data_memory: little-endian bytes, combinational read, write on clk.
    logic [7:0]  mem [0:MEM_BYTES-1];
    logic        mem_init_done = 1'b0;
    int          ra;
    logic [31:0] raw_word;

    always_comb begin
        ra = int'(mem_address[9:0]);
        raw_word = {mem[(ra + 3) % MEM_BYTES], mem[(ra + 2) % MEM_BYTES],
                    mem[(ra + 1) % MEM_BYTES], mem[ra]};
        case (mem_size)
            2'b00:   mem_read_data = mem_unsigned_load ? {24'h0, raw_word[7:0]}
                                                       : {{24{raw_word[7]}}, raw_word[7:0]};
            2'b01:   mem_read_data = mem_unsigned_load ? {16'h0, raw_word[15:0]}
                                                       : {{16{raw_word[15]}}, raw_word[15:0]};
            default: mem_read_data = raw_word;
        endcase
    end

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
            mem[8'h08] <= 8'h34;
            mem[8'h09] <= 8'h12;
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < 4; i++) begin
                    mem[256 + 16 * p + 4 * i]     <= 8'(i);
                    mem[256 + 16 * p + 4 * i + 1] <= 8'(p);
                    mem[256 + 16 * p + 4 * i + 3] <= 8'hA0;
                end
            end
            for (int i = 0; i < 4; i++) mem[32 + i] <= 8'h11;
            mem_init_done <= 1'b1;
        end else if (mem_write) begin
            mem[ra] <= mem_write_data[7:0];
            if (mem_size != 2'b00) mem[(ra + 1) % MEM_BYTES] <= mem_write_data[15:8];
            if (mem_size == 2'b10) begin
                mem[(ra + 2) % MEM_BYTES] <= mem_write_data[23:16];
                mem[(ra + 3) % MEM_BYTES] <= mem_write_data[31:24];
            end
        end
    end

    task automatic drive(input int p, input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [1:0] s, input logic u);
        if (p == 0) begin
            req0_valid = v; req0_addr = a; req0_wdata = d;
            req0_write = w; req0_size = s; req0_unsigned = u;
        end else begin
            req1_valid = v; req1_addr = a; req1_wdata = d;
            req1_write = w; req1_size = s; req1_unsigned = u;
        end
    endtask

    // Issues one request on port p and waits for its response; lat = edges from accept
    // to response (-1 if it never came).
    task automatic do_req(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [1:0] s, input logic u,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic other, output logic touched);
        logic got_ready;
        lat = -1; rd = '0; er = 1'b0; other = 1'b0; touched = 1'b0; got_ready = 1'b0;
        @(negedge clk);
        drive(p, 1'b1, a, d, w, s, u);
        for (int i = 0; i < 8; i++) begin
            #1;
            if ((p == 0) ? req0_ready : req1_ready) begin
                got_ready = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got_ready) begin
            drive(p, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
            return;
        end
        @(posedge clk);
        #1 drive(p, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_read || mem_write) touched = 1'b1;
            if ((p == 0) ? rsp1_valid : rsp0_valid) other = 1'b1;
            if ((p == 0) ? rsp0_valid : rsp1_valid) begin
                lat = k;
                rd  = (p == 0) ? rsp0_rdata : rsp1_rdata;
                er  = (p == 0) ? rsp0_err : rsp1_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 1'b1, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0);
        drive(1, 1'b1, 32'h4, 32'h0, 1'b0, 2'b10, 1'b0);
        repeat (3) @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
        end
        vectors++;
        if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, mem_read, mem_write} !== 6'b0 ||
            rsp0_rdata !== 32'h0 || mem_address !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: rsp_v=%b%b err=%b%b rdata0=%h mem_rd=%b mem_wr=%b addr=%h required all zero",
                     rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_rdata, mem_read, mem_write, mem_address);
        end
        drive(0, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        $display("reset: ready=%b%b rsp_valid=%b%b", req0_ready, req1_ready, rsp0_valid, rsp1_valid);
    endtask

    task automatic test_load_half();
        int lat; logic [31:0] rd; logic er, oth, tch;
        do_req(0, 32'h08, 32'h0, 1'b0, 2'b01, 1'b0, lat, rd, er, oth, tch);
        $display("p0 lh 0x08: lat=%0d rdata=%h err=%b", lat, rd, er);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL load_half_latency: got %0d required 2", lat);
        end
        vectors++;
        if (rd !== 32'h0000_1234 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL load_half_data: got %h err %b required 00001234 err 0", rd, er);
        end
        vectors++;
        if (oth !== 1'b0 || tch !== 1'b1) begin
            miscompares++;
            $display("FAIL load_half_routing: other_rsp %b mem_touched %b required 0 1", oth, tch);
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er, oth, tch;
        do_req(1, 32'h10, 32'hFFFF_CAFE, 1'b1, 2'b01, 1'b0, lat, rd, er, oth, tch);
        $display("p1 sh 0x10: lat=%0d rdata=%h err=%b", lat, rd, er);
        vectors++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0 || oth !== 1'b0) begin
            miscompares++;
            $display("FAIL store_half_rsp: lat %0d rdata %h err %b other %b required 2 00000000 0 0",
                     lat, rd, er, oth);
        end
        vectors++;
        if ({mem[19], mem[18], mem[17], mem[16]} !== 32'h0000_CAFE) begin
            miscompares++;
            $display("FAIL store_half_mem: got %h required 0000cafe",
                     {mem[19], mem[18], mem[17], mem[16]});
        end
        do_req(1, 32'h10, 32'h0, 1'b0, 2'b01, 1'b1, lat, rd, er, oth, tch);
        $display("p1 lhu 0x10: lat=%0d rdata=%h err=%b", lat, rd, er);
        vectors++;
        if (rd !== 32'h0000_CAFE || er !== 1'b0 || lat !== 2) begin
            miscompares++;
            $display("FAIL lhu_data: got %h err %b lat %0d required 0000cafe 0 2", rd, er, lat);
        end
        do_req(1, 32'h10, 32'h0, 1'b0, 2'b01, 1'b0, lat, rd, er, oth, tch);
        $display("p1 lh 0x10: lat=%0d rdata=%h err=%b", lat, rd, er);
        vectors++;
        if (rd !== 32'hFFFF_CAFE || er !== 1'b0) begin
            miscompares++;
            $display("FAIL lh_data: got %h err %b required ffffcafe 0", rd, er);
        end
    endtask

    // Last accept was port 1, so contention must start with port 0.
    task automatic test_round_robin();
        int cnt [2];
        int g;
        logic found, oth, got;
        logic [31:0] rd;
        cnt[0] = 0; cnt[1] = 0;
        @(negedge clk);
        drive(0, 1'b1, 32'h100, 32'h0, 1'b0, 2'b10, 1'b0);
        drive(1, 1'b1, 32'h110, 32'h0, 1'b0, 2'b10, 1'b0);
        for (int n = 0; n < 8; n++) begin
            found = 1'b0;
            for (int i = 0; i < 8; i++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            vectors++;
            if (!found || (req0_ready && req1_ready)) begin
                miscompares++;
                $display("FAIL rr_ready_%0d: ready=%b%b required exactly one", n, req0_ready, req1_ready);
                break;
            end
            g = req1_ready ? 1 : 0;
            vectors++;
            if (g !== (n % 2)) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: got port %0d required port %0d", n, g, n % 2);
            end
            @(posedge clk);
            #1;
            cnt[g]++;
            if (cnt[g] < 4)
                drive(g, 1'b1, 32'(256 + 16 * g + 4 * cnt[g]), 32'h0, 1'b0, 2'b10, 1'b0);
            else
                drive(g, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
            oth = 1'b0; got = 1'b0; rd = '0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if ((g == 0) ? rsp1_valid : rsp0_valid) oth = 1'b1;
                if ((g == 0) ? rsp0_valid : rsp1_valid) begin
                    got = 1'b1;
                    rd = (g == 0) ? rsp0_rdata : rsp1_rdata;
                    break;
                end
            end
            $display("rr %0d: grant=%0d rdata=%h other_rsp=%b", n, g, rd, oth);
            vectors++;
            if (!got || oth || rd !== (32'hA000_0000 | 32'(g << 8) | 32'(cnt[g] - 1))) begin
                miscompares++;
                $display("FAIL rr_rsp_%0d: got %h seen %b other %b required %h on port %0d only", n, rd, got, oth,
                         32'hA000_0000 | 32'(g << 8) | 32'(cnt[g] - 1), g);
            end
        end
        drive(0, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic er, oth, tch;
        do_req(0, 32'h3FE, 32'h0, 1'b0, 2'b10, 1'b0, lat, rd, er, oth, tch);
        $display("p0 lw 0x3fe: lat=%0d err=%b touched=%b", lat, er, tch);
        vectors++;
        if (er !== 1'b1 || lat !== 1 || rd !== 32'h0 || tch !== 1'b0) begin
            miscompares++;
            $display("FAIL range_word_3fe: err %b lat %0d rdata %h touched %b required 1 1 00000000 0",
                     er, lat, rd, tch);
        end
        do_req(0, 32'h3FC, 32'h0, 1'b0, 2'b10, 1'b0, lat, rd, er, oth, tch);
        $display("p0 lw 0x3fc: lat=%0d err=%b touched=%b", lat, er, tch);
        vectors++;
        if (er !== 1'b0 || lat !== 2 || tch !== 1'b1) begin
            miscompares++;
            $display("FAIL range_word_3fc: err %b lat %0d touched %b required 0 2 1", er, lat, tch);
        end
        do_req(0, 32'h3FF, 32'h0, 1'b0, 2'b00, 1'b0, lat, rd, er, oth, tch);
        $display("p0 lb 0x3ff: lat=%0d err=%b touched=%b", lat, er, tch);
        vectors++;
        if (er !== 1'b0 || tch !== 1'b1) begin
            miscompares++;
            $display("FAIL range_byte_3ff: err %b touched %b required 0 1", er, tch);
        end
        do_req(0, 32'h0, 32'h0, 1'b0, 2'b11, 1'b0, lat, rd, er, oth, tch);
        $display("p0 size=11 0x0: lat=%0d err=%b touched=%b", lat, er, tch);
        vectors++;
        if (er !== 1'b1 || lat !== 1 || tch !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_size: err %b lat %0d touched %b required 1 1 0", er, lat, tch);
        end
    endtask

    task automatic test_align();
        int lat; logic [31:0] rd; logic er, oth, tch;
        do_req(0, 32'h0F, 32'h0, 1'b0, 2'b01, 1'b0, lat, rd, er, oth, tch);
        $display("p0 lh 0x0f: lat=%0d err=%b touched=%b", lat, er, tch);
        vectors++;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        if (er !== 1'b1 || lat !== 1 || tch !== 1'b0) begin
            miscompares++;
            $display("FAIL misaligned_half: err %b lat %0d touched %b required 1 1 0", er, lat, tch);
        end
`else
        if (er !== 1'b0 || lat !== 2 || tch !== 1'b1) begin
            miscompares++;
            $display("FAIL misaligned_half: err %b lat %0d touched %b required 0 2 1", er, lat, tch);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        logic got_ready, seen_rsp;
        got_ready = 1'b0;
        seen_rsp = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 8; i++) begin
            #1;
            if (req0_ready) begin
                got_ready = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!got_ready) begin
            miscompares++;
            $display("FAIL mid_reset_accept: port 0 never ready");
        end
        @(posedge clk);
        #1 drive(0, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        vectors++;
        if (mem_write !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_access: mem_write %b required 1", mem_write);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (mem_write !== 1'b0 || mem_address !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_memwr: mem_write %b addr %h required 0 00000000", mem_write, mem_address);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) seen_rsp = 1'b1;
        end
        $display("mid-access reset: mem[0x20]=%h rsp_seen=%b", {mem[35], mem[34], mem[33], mem[32]}, seen_rsp);
        vectors++;
        if ({mem[35], mem[34], mem[33], mem[32]} !== 32'h1111_1111 || seen_rsp) begin
            miscompares++;
            $display("FAIL mid_reset_nowrite: mem %h rsp_seen %b required 11111111 0",
                     {mem[35], mem[34], mem[33], mem[32]}, seen_rsp);
        end
        drive(0, 1'b1, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0);
        drive(1, 1'b1, 32'h4, 32'h0, 1'b0, 2'b10, 1'b0);
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_reset_first_grant: ready %b%b required 10", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        test_reset();
        test_load_half();
        test_store_load();
        test_round_robin();
        test_range();
        test_align();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data_memory.
- Port 0 serves the core load/store unit; port 1 serves a debug/program-loader master.
- Accepts one request at a time over valid/ready, runs exactly one memory access, then returns a registered response.
- Arbitration is round-robin; size and sign-extension fields pass straight through to the memory.

Parameters:
- ADDR_W, 32, address width of requests and memory port.
- DATA_W, 32, data width.
- MEM_BYTES, 1024, memory size in bytes; addresses >= MEM_BYTES are out of range.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- req0_valid / req1_valid  in  1  request present on port 0 / port 1.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid & ready.
- reqN_addr  in  ADDR_W  byte address.
- reqN_wdata  in  DATA_W  store data (low bytes used per size).
- reqN_write  in  1  1=store, 0=load.
- reqN_size  in  2  00 byte, 01 half, 10 word.
- reqN_unsigned  in  1  zero-extend load (lbu/lhu).
- rspN_valid  out  1  one-cycle response pulse to port N.
- rspN_rdata  out  DATA_W  load result (0 for stores and errors).
- rspN_err  out  1  access rejected.
- mem_address  out  ADDR_W  to data_memory.address.
- mem_write_data  out  DATA_W  to data_memory.write_data.
- mem_read  out  1  to data_memory.mem_read.
- mem_write  out  1  to data_memory.mem_write.
- mem_size  out  2  to data_memory.size.
- mem_unsigned_load  out  1  to data_memory.unsigned_load.
- mem_read_data  in  DATA_W  from data_memory.read_data; combinational, valid same cycle.

Behaviour:
- FSM states:
  - IDLE: reqN_ready=1 for the granted port only.
  - ACCESS: memory is driven.
  - RESP: response is presented.
- IDLE transitions:
  - On accept, latch addr, wdata, write, size, unsigned and the port id; go to ACCESS.
  - If the latched request is out of range (addr + bytes(size) > MEM_BYTES), go to RESP with err=1 and memory untouched.
- ACCESS (exactly one cycle):
  - mem_read = !write; mem_write = write; remaining mem_* driven from the latched request.
  - The store commits on the rising edge ending ACCESS.
  - Load data is captured from mem_read_data on that same edge.
  - Go to RESP.
- RESP (exactly one cycle):
  - rsp_valid=1 on the latched port only; rdata/err are held in registers.
  - Go to IDLE.
- Latency: accept at edge N, rsp_valid high during cycle N+2. Throughput: one access per 3 cycles; req ready is low in ACCESS and RESP.
- Arbitration: pointer last_grant, reset value 1, so port 0 wins first.
  - Both valid in IDLE: grant !last_grant.
  - Only one valid: grant it.
  - last_grant updates on accept only.
- Requesters must hold valid and all fields stable until accepted. Deasserting valid before accept is legal (no access is made).
- Outside ACCESS: mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, mem_size=00, mem_unsigned_load=0.
- Reset values: state=IDLE, all rsp*_valid/err=0, rdata=0, ready outputs=0 during reset. On release, ready follows the IDLE grant rule combinationally.
- Reset asserted mid-ACCESS:
  - mem_write drops asynchronously; no write commits unless a clock edge occurred before reset.
  - The pending response is discarded.
- size=11 is illegal: treated as err=1 with no memory access.

Optional Feature:
- Macro DMEM_ARB_ALIGN_CHECK_EN.
- Defined: half access at an odd address, or word access with addr[1:0]!=0, goes IDLE->RESP with err=1 and no memory access.
- Undefined: misaligned accesses are passed to data_memory unchanged, and err reflects only range/size checks.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state encoding ST_IDLE/ST_ACCESS/ST_RESP.
  - function size_bytes(size).
- No sub-module is needed; the round-robin pick is two lines of logic.
- dmem_arbiter instantiates nothing; the top level wires it to data_memory.

Test Plan:
- Port 0 load half from 0x08 (memory 0x00001234), unsigned=0 -> rsp0_valid two cycles after accept, rsp0_rdata=0x00001234, err=0.
- Port 1 store half 0xFFFFCAFE at 0x10, then port 1 lhu 0x10 -> second response rdata=0x0000CAFE; lh returns 0xFFFFCAFE.
- Both ports valid continuously in IDLE with 4 requests each -> grants alternate 0,1,0,1…, and each response goes only to the owning port.
- Load word at 0x3FE with MEM_BYTES=1024 -> err=1, mem_read/mem_write never asserted.
- With DMEM_ARB_ALIGN_CHECK_EN defined, lh at 0x0F -> err=1, no memory access. Without it, memory is accessed and err=0.
- Pulse reset low during ACCESS of a store to 0x20 before the clock edge -> no write observed at 0x20, no rsp pulse; after release the first grant goes to port 0.
